// File: rtl/erosion_stream_if.sv
// rtl/erosion_stream_if.sv - pixel stream bundle between a raster source and the erosion block
interface erosion_stream_if #(
  parameter int PIX_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic [PIX_W-1:0] out_pixel;
  logic             out_sof;
  logic             out_eol;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  in_ready, out_valid, out_pixel, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output in_ready, out_valid, out_pixel, out_sof, out_eol
  );
endinterface

// File: rtl/erosion_stream.sv
// rtl/erosion_stream.sv - streaming 3x3 grayscale erosion (min filter) in raster order
module erosion_stream #(
  parameter int PIX_W = 10,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          clk,
  input  logic          reset,
  erosion_stream_if.slave s
);

  localparam int HIST_LEN = 2 * IMG_W + 3;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int N_W      = $clog2(NPIX + IMG_W + 2);
  localparam int R_W      = $clog2(IMG_H);
  localparam int C_W      = $clog2(IMG_W);

  localparam logic [PIX_W-1:0] MAXV        = '1;
  localparam logic [N_W-1:0]   N_FIRST_WIN = N_W'(IMG_W + 1);
  localparam logic [N_W-1:0]   N_LAST_PIX  = N_W'(NPIX - 1);
  localparam logic [N_W-1:0]   N_LAST_PAD  = N_W'(NPIX + IMG_W);
  localparam logic [C_W-1:0]   C_LAST      = C_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  // hist_q[0] is the newest sample; hist_q[i] is the sample i positions older.
  logic [PIX_W-1:0] hist_q [HIST_LEN];
  logic [PIX_W-1:0] hist_d [HIST_LEN];

  // n_q counts samples (pixels and pads) shifted in since the frame started.
  logic [N_W-1:0] n_q, n_d;

  // win_q: history currently holds a complete window centred on (cr_q, cc_q).
  logic           win_q, win_d;
  logic [R_W-1:0] cr_q, cr_d;
  logic [C_W-1:0] cc_q, cc_d;

  logic             out_valid_q;
  logic [PIX_W-1:0] out_pixel_q;
  logic             out_sof_q;
  logic             out_eol_q;

  logic             ready;
  logic             xfer;
  logic             shift;
  logic             restart;
  logic [PIX_W-1:0] shift_pix;
  logic [PIX_W-1:0] win_min;
  logic [PIX_W-1:0] tap;

  assign ready = (state_q != S_FLUSH);
  assign xfer  = s.in_valid & ready;

  // Frame sequencing: decide whether a sample enters the history this cycle and where the FSM goes.
  always_comb begin
    state_d   = state_q;
    shift     = 1'b0;
    restart   = 1'b0;
    shift_pix = s.in_pixel;
    case (state_q)
      S_IDLE: begin
        if (xfer && s.in_sof) begin
          shift   = 1'b1;
          restart = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          shift = 1'b1;
          if (s.in_sof) begin
            restart = 1'b1;
          end else if (n_q == N_LAST_PIX) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Pads stand in for row IMG_H and push the last line's windows out.
        shift     = 1'b1;
        shift_pix = MAXV;
        if (n_q == N_LAST_PAD) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // History shift, sample counter and centre-position tracking for the window being completed.
  always_comb begin
    hist_d = hist_q;
    n_d    = n_q;
    win_d  = 1'b0;
    cr_d   = cr_q;
    cc_d   = cc_q;
    if (shift) begin
      if (restart) begin
        // New frame: stale history must never leak into the first windows.
        for (int i = 0; i < HIST_LEN; i++) begin
          hist_d[i] = MAXV;
        end
        hist_d[0] = s.in_pixel;
        n_d       = N_W'(1);
      end else begin
        for (int i = HIST_LEN - 1; i > 0; i--) begin
          hist_d[i] = hist_q[i-1];
        end
        hist_d[0] = shift_pix;
        n_d       = n_q + N_W'(1);
        if (n_q >= N_FIRST_WIN) begin
          win_d = 1'b1;
          if (n_q == N_FIRST_WIN) begin
            cr_d = '0;
            cc_d = '0;
          end else if (cc_q == C_LAST) begin
            cc_d = '0;
            cr_d = cr_q + R_W'(1);
          end else begin
            cc_d = cc_q + C_W'(1);
          end
        end
      end
    end
  end

  // Min of the nine neighbours, with out-of-image taps forced to MAXV.
  always_comb begin
    win_min = MAXV;
    tap     = MAXV;
    for (int row = 0; row < 3; row++) begin
      for (int col = 0; col < 3; col++) begin
        tap = hist_q[(2 - row) * IMG_W + 2 - col];
        if ((row == 0 && cr_q == '0) ||
            (col == 0 && cc_q == '0) ||
            (col == 2 && cc_q == C_LAST)) begin
          tap = MAXV;
        end
        if (tap < win_min) begin
          win_min = tap;
        end
      end
    end
  end

  // State, history and position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      win_q   <= 1'b0;
      cr_q    <= '0;
      cc_q    <= '0;
      for (int i = 0; i < HIST_LEN; i++) begin
        hist_q[i] <= MAXV;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      win_q   <= win_d;
      cr_q    <= cr_d;
      cc_q    <= cc_d;
      hist_q  <= hist_d;
    end
  end

  // Registered output stage: one cycle after a window completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      out_valid_q <= win_q;
      if (win_q) begin
        out_pixel_q <= win_min;
      end
      out_sof_q <= win_q && (cr_q == '0) && (cc_q == '0);
      out_eol_q <= win_q && (cc_q == C_LAST);
    end
  end

  assign s.in_ready  = ready;
  assign s.out_valid = out_valid_q;
  assign s.out_pixel = out_pixel_q;
  assign s.out_sof   = out_sof_q;
  assign s.out_eol   = out_eol_q;

endmodule
